// File: rtl/tpu_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// tpu_seq_ctrl_if
// Datapath-side bundle between the run sequencer and the TOP_tpu datapath
// (weight FIFO, systolic array weight-load strobe, activation SRAM address).
//
// Signals:
//   fifo_empty        FIFO -> sequencer   weight FIFO empty flag
//   fifo_read_enable  sequencer -> FIFO   weight FIFO pop, 1-cycle pulse
//   we_rl             sequencer -> array  weight load strobe, 1-cycle pulse
//   sram_address      sequencer -> SRAM   activation read address
//   valid_address     sequencer -> SRAM   sram_address qualifier
//
// Modports:
//   master  the sequencer
//   slave   the datapath
// ---------------------------------------------------------------------------
interface tpu_seq_ctrl_if #(
    parameter int ADDRESSSIZE = 10
);
    logic                   fifo_empty;
    logic                   fifo_read_enable;
    logic                   we_rl;
    logic [ADDRESSSIZE-1:0] sram_address;
    logic                   valid_address;

    modport master (
        input  fifo_empty,
        output fifo_read_enable,
        output we_rl,
        output sram_address,
        output valid_address
    );

    modport slave (
        output fifo_empty,
        input  fifo_read_enable,
        input  we_rl,
        input  sram_address,
        input  valid_address
    );
endinterface

// File: rtl/tpu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tpu_seq_ctrl
// Run sequencer for the TOP_tpu datapath. A run pops one weight tile from the
// weight FIFO, pulses the array weight-load strobe, streams a run of
// consecutive activation SRAM addresses, waits for the array pipeline to
// drain, then pulses end_.
//
// Ports:
//   clk          clock, rising edge
//   rstn         asynchronous active-low reset
//   start        run request, sampled only while idle
//   base_addr    first activation address, latched at start
//   num_vecs     number of activation vectors, latched at start
//   dp           datapath bundle (tpu_seq_ctrl_if.master)
//   busy         high whenever a run is in progress
//   end_         run complete, 1-cycle pulse
//   run_cycles   (perf build) cycles of the last run, IDLE exit to DONE
//   stall_cycles (perf build) weight-wait cycles of the last run
//
// Optional feature: define TPU_SEQ_CTRL_PERF_EN to add the run_cycles and
// stall_cycles performance counters.
//
// All outputs come straight from flops loaded from the next-state decode, so
// they are glitch-free and equal to a decode of the current state.
// DRAIN_CYCLES must lie in 1..255 (8-bit drain counter).
// ---------------------------------------------------------------------------
module tpu_seq_ctrl #(
    parameter int ADDRESSSIZE  = 10,
    parameter int NUM_PE_ROWS  = 8,
    parameter int MATRIX_SIZE  = 8,
    parameter int DRAIN_CYCLES = NUM_PE_ROWS + MATRIX_SIZE - 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic [ADDRESSSIZE-1:0] base_addr,
    input  logic [ADDRESSSIZE-1:0] num_vecs,
    tpu_seq_ctrl_if.master         dp,
    output logic                   busy,
`ifdef TPU_SEQ_CTRL_PERF_EN
    output logic [31:0]            run_cycles,
    output logic [15:0]            stall_cycles,
`endif
    output logic                   end_
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_W,
        S_POP,
        S_LOAD,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [7:0]             DRAIN_LAST = 8'(DRAIN_CYCLES - 1);
    localparam logic [ADDRESSSIZE-1:0] ONE_A      = ADDRESSSIZE'(1);

    state_t                 state_q, state_d;
    logic [ADDRESSSIZE-1:0] base_q, base_d;
    logic [ADDRESSSIZE-1:0] num_q, num_d;
    logic [ADDRESSSIZE-1:0] vec_cnt_q, vec_cnt_d;
    logic [7:0]             drain_cnt_q, drain_cnt_d;
    logic [ADDRESSSIZE-1:0] addr_q, addr_d;

    logic                   fifo_re_q;
    logic                   we_rl_q;
    logic                   valid_q;
    logic                   busy_q;
    logic                   end_q;

    // ------------------------------------------------------------------
    // Next-state / datapath decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        num_d       = num_q;
        vec_cnt_d   = vec_cnt_q;
        drain_cnt_d = drain_cnt_q;
        addr_d      = addr_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    num_d   = num_vecs;
                    state_d = dp.fifo_empty ? S_WAIT_W : S_POP;
                end
            end
            S_WAIT_W: begin
                if (!dp.fifo_empty) begin
                    state_d = S_POP;
                end
            end
            S_POP: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                if (num_q == '0) begin
                    // Empty run: skip both stream and drain.
                    state_d = S_DONE;
                end else begin
                    state_d   = S_STREAM;
                    addr_d    = base_q;
                    vec_cnt_d = '0;
                end
            end
            S_STREAM: begin
                // vec_cnt_q is the index of the vector presented this cycle.
                if (vec_cnt_q == num_q - ONE_A) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = '0;
                end else begin
                    vec_cnt_d = vec_cnt_q + ONE_A;
                    addr_d    = addr_q + ONE_A;   // wraps modulo 2^ADDRESSSIZE
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, counters and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            num_q       <= '0;
            vec_cnt_q   <= '0;
            drain_cnt_q <= '0;
            addr_q      <= '0;
            fifo_re_q   <= 1'b0;
            we_rl_q     <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            end_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            num_q       <= num_d;
            vec_cnt_q   <= vec_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            addr_q      <= addr_d;
            fifo_re_q   <= (state_d == S_POP);
            we_rl_q     <= (state_d == S_LOAD);
            valid_q     <= (state_d == S_STREAM);
            busy_q      <= (state_d != S_IDLE);
            end_q       <= (state_d == S_DONE);
        end
    end

    assign dp.fifo_read_enable = fifo_re_q;
    assign dp.we_rl            = we_rl_q;
    assign dp.sram_address     = addr_q;
    assign dp.valid_address    = valid_q;
    assign busy                = busy_q;
    assign end_                = end_q;

`ifdef TPU_SEQ_CTRL_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters. run_cnt_q holds the run cycles already spent
    // before the current one, so the total published from DONE is +1.
    // ------------------------------------------------------------------
    logic [31:0] run_cnt_q, run_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] run_total;
    logic [31:0] run_cycles_q;
    logic [15:0] stall_cycles_q;

    assign run_total = (&run_cnt_q) ? run_cnt_q : run_cnt_q + 32'd1;

    always_comb begin
        run_cnt_d   = run_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (state_q == S_IDLE) begin
            run_cnt_d   = '0;
            stall_cnt_d = '0;
        end else begin
            run_cnt_d = run_total;
            if (state_q == S_WAIT_W && !(&stall_cnt_q)) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            run_cnt_q      <= '0;
            stall_cnt_q    <= '0;
            run_cycles_q   <= '0;
            stall_cycles_q <= '0;
        end else begin
            run_cnt_q   <= run_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            if (state_q == S_DONE) begin
                run_cycles_q   <= run_total;
                stall_cycles_q <= stall_cnt_q;
            end
        end
    end

    assign run_cycles   = run_cycles_q;
    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_tpu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tpu_seq_ctrl
// Directed bench for tpu_seq_ctrl: baseline run, weight-FIFO stall, address
// wrap, empty run, ignored mid-run start with a back-to-back run, and reset
// during drain followed by a clean run.
// ---------------------------------------------------------------------------
module tb_tpu_seq_ctrl;

    localparam int DRAIN = 15;

    logic       clk;
    logic       rstn;
    logic       start;
    logic [9:0] base_addr;
    logic [9:0] num_vecs;
    logic       busy;
    logic       end_;
`ifdef TPU_SEQ_CTRL_PERF_EN
    logic [31:0] run_cycles;
    logic [15:0] stall_cycles;
`endif

    int errors = 0;
    int checks = 0;

    tpu_seq_ctrl_if #(.ADDRESSSIZE(10)) dp_if ();

    tpu_seq_ctrl #(
        .ADDRESSSIZE (10),
        .NUM_PE_ROWS (8),
        .MATRIX_SIZE (8),
        .DRAIN_CYCLES(DRAIN)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .base_addr   (base_addr),
        .num_vecs    (num_vecs),
        .dp          (dp_if.master),
        .busy        (busy),
`ifdef TPU_SEQ_CTRL_PERF_EN
        .run_cycles  (run_cycles),
        .stall_cycles(stall_cycles),
`endif
        .end_        (end_)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic outs(input string tag, input logic fre, input logic we,
                        input logic va, input logic bsy, input logic en);
        chk({tag, ".fifo_read_enable"}, {31'd0, dp_if.fifo_read_enable}, {31'd0, fre});
        chk({tag, ".we_rl"},            {31'd0, dp_if.we_rl},            {31'd0, we});
        chk({tag, ".valid_address"},    {31'd0, dp_if.valid_address},    {31'd0, va});
        chk({tag, ".busy"},             {31'd0, busy},                   {31'd0, bsy});
        chk({tag, ".end_"},             {31'd0, end_},                   {31'd0, en});
    endtask

    // One complete run starting from an IDLE cycle (called #1 after an edge).
    // w: cycles the FIFO stays empty; mid: re-pulse start during STREAM;
    // abort: pull rstn low in the middle of DRAIN.
    task automatic do_run(input logic [9:0] b, input logic [9:0] n, input int w,
                          input bit mid, input bit abort);
        logic [9:0] a;
        int         exp_run;
        $display("run: base=%0d num_vecs=%0d stall=%0d mid_start=%0d abort=%0d",
                 b, n, w, mid, abort);
        dp_if.fifo_empty = (w > 0);
        start     = 1'b1;
        base_addr = b;
        num_vecs  = n;
        tick();
        start     = 1'b0;
        base_addr = ~b;       // must not matter: values were latched
        num_vecs  = 10'd3;
        for (int i = 0; i < w; i++) begin
            outs("wait", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            if (i == w - 1) dp_if.fifo_empty = 1'b0;
            tick();
        end
        outs("pop", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        outs("load", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        a = b;
        for (int k = 0; k < int'(n); k++) begin
            outs("stream", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            chk("stream.sram_address", {22'd0, dp_if.sram_address}, {22'd0, a});
            start = (mid && k == 2);
            a = a + 10'd1;
            tick();
        end
        start = 1'b0;
        if (n != 10'd0) begin
            for (int d = 0; d < DRAIN; d++) begin
                if (abort && d == 5) begin
                    rstn = 1'b0;
                    #1;
                    outs("rst_now", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                    chk("rst_now.sram_address", {22'd0, dp_if.sram_address}, 32'd0);
                    tick();
                    tick();
                    outs("rst_held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                    rstn = 1'b1;
                    for (int j = 0; j < DRAIN; j++) begin
                        tick();
                        chk("post_rst.end_", {31'd0, end_}, 32'd0);
                    end
                    outs("post_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                    return;
                end
                outs("drain", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
                chk("drain.sram_address", {22'd0, dp_if.sram_address}, {22'd0, a - 10'd1});
                tick();
            end
        end
        outs("done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        outs("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_run = w + 3 + ((n != 10'd0) ? int'(n) + DRAIN : 0);
`ifdef TPU_SEQ_CTRL_PERF_EN
        chk("perf.run_cycles",   run_cycles,            exp_run);
        chk("perf.stall_cycles", {16'd0, stall_cycles}, w);
`endif
        $display("run complete: expected run length %0d cycles", exp_run);
    endtask

    initial begin
        rstn             = 1'b0;
        start            = 1'b0;
        base_addr        = '0;
        num_vecs         = '0;
        dp_if.fifo_empty = 1'b0;
        tick();
        tick();
        outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.sram_address", {22'd0, dp_if.sram_address}, 32'd0);
`ifdef TPU_SEQ_CTRL_PERF_EN
        chk("reset.run_cycles",   run_cycles,            32'd0);
        chk("reset.stall_cycles", {16'd0, stall_cycles}, 32'd0);
`endif
        rstn = 1'b1;
        tick();

        do_run(10'd0,    10'd8, 0, 1'b0, 1'b0);   // baseline
        tick();
        do_run(10'd0,    10'd8, 3, 1'b0, 1'b0);   // FIFO empty for 3 cycles
        tick();
        do_run(10'd1020, 10'd6, 0, 1'b0, 1'b0);   // address wrap
        tick();
        do_run(10'd5,    10'd0, 0, 1'b0, 1'b0);   // empty run
        tick();
        do_run(10'd64,   10'd8, 0, 1'b1, 1'b0);   // mid-run start ignored
        do_run(10'd64,   10'd8, 0, 1'b0, 1'b0);   // back-to-back run
        tick();
        do_run(10'd200,  10'd8, 0, 1'b0, 1'b1);   // reset during drain
        tick();
        do_run(10'd3,    10'd8, 0, 1'b0, 1'b0);   // clean run after reset

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
